cpu_alu: RTL and testbench

Registered 32-bit integer ALU used by the CPU execute stage. It accepts two operands, a 4-bit operation code and the current flags. One clock later it returns a 32-bit result and the updated flags. Dividers, long shifts and long multiplies are separate blocks and are outside this scope.

---
 rtl/cpu_alu.sv | 237 +++++++++++++++++++++++
 tb/tb_cpu_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module   : cpu_alu
// Purpose  : Registered integer ALU for the CPU execute stage. An operation
//            presented with in_valid is computed combinationally and captured
//            on the next rising clock edge. result, flags_out and out_valid
//            all appear together one cycle after the operation is accepted.
//            A new operation can be accepted on every cycle.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous reset, active-high
//            in_valid   - operation strobe; operands are sampled when high
//            a, b       - operands (b is also the shift amount)
//            oper       - 4-bit operation code
//            flags_in   - current flags {N,V,C,Z} (bit3..bit0)
//            result     - registered result
//            flags_out  - registered flags, same bit order as flags_in
//            out_valid  - one-cycle pulse per accepted operation
// Revision : 1.0 - initial release
// ============================================================================
module cpu_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       oper,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out,
    output logic             out_valid
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] C_OP_ADD = 4'd0;
    localparam logic [3:0] C_OP_ADC = 4'd1;
    localparam logic [3:0] C_OP_SUB = 4'd2;
    localparam logic [3:0] C_OP_SBC = 4'd3;
    localparam logic [3:0] C_OP_RSB = 4'd4;
    localparam logic [3:0] C_OP_MUL = 4'd5;
    localparam logic [3:0] C_OP_AND = 4'd6;
    localparam logic [3:0] C_OP_ORR = 4'd7;
    localparam logic [3:0] C_OP_XOR = 4'd8;
    localparam logic [3:0] C_OP_BIC = 4'd9;
    localparam logic [3:0] C_OP_LSL = 4'd10;
    localparam logic [3:0] C_OP_LSR = 4'd11;
    localparam logic [3:0] C_OP_ASR = 4'd12;
    localparam logic [3:0] C_OP_ROR = 4'd13;
    localparam logic [3:0] C_OP_CPY = 4'd14;

    // Full shift distance, used to split shift amounts into <W, ==W, >W.
    localparam logic [WIDTH-1:0] C_SHIFT_FULL = WIDTH'(WIDTH);
    // Same value in a narrow width for the rotate left-shift complement.
    localparam logic [SHW:0]     C_ROR_FULL   = (SHW+1)'(WIDTH);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q,  flags_d;
    logic             valid_q;

    // ------------------------------------------------------------------
    // Shared adder: every arithmetic op is expressed as x + y + cin so
    // carry and overflow come out of a single 33-bit sum.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] arith_x;
    logic [WIDTH-1:0] arith_y;
    logic             arith_cin;
    logic [WIDTH:0]   arith_sum;

    always_comb begin
        arith_x   = a;
        arith_y   = b;
        arith_cin = 1'b0;
        case (oper)
            C_OP_ADC: arith_cin = flags_in[1];
            C_OP_SUB: begin
                arith_y   = ~b;
                arith_cin = 1'b1;
            end
            C_OP_SBC: begin
                arith_y   = ~b;
                arith_cin = flags_in[1];
            end
            C_OP_RSB: begin
                arith_x   = b;
                arith_y   = ~a;
                arith_cin = 1'b1;
            end
            default: ;
        endcase
        arith_sum = {1'b0, arith_x} + {1'b0, arith_y} + {{WIDTH{1'b0}}, arith_cin};
    end

    // ------------------------------------------------------------------
    // Shifter datapaths. Each shift is widened by one bit so the last bit
    // shifted out lands in a fixed position and becomes the carry.
    // ------------------------------------------------------------------
    logic [SHW-1:0]   amt_lo;
    logic             amt_zero;
    logic             amt_small;
    logic             amt_full;
    logic [WIDTH:0]   lsl_tmp;
    logic [WIDTH:0]   lsr_tmp;
    logic [WIDTH:0]   asr_tmp;
    logic [SHW:0]     ror_left;
    logic [WIDTH-1:0] ror_val;
    logic [WIDTH-1:0] mul_val;

    always_comb begin
        amt_lo    = b[SHW-1:0];
        amt_zero  = (b == '0);
        amt_small = (b < C_SHIFT_FULL);
        amt_full  = (b == C_SHIFT_FULL);
        lsl_tmp   = {1'b0, a} << amt_lo;          // carry in bit WIDTH
        lsr_tmp   = {a, 1'b0} >> amt_lo;          // carry in bit 0
        asr_tmp   = $signed({a, 1'b0}) >>> amt_lo; // carry in bit 0
        // A left shift by the full width yields zero, so amt_lo==0 gives a.
        ror_left  = C_ROR_FULL - {1'b0, amt_lo};
        ror_val   = (a >> amt_lo) | (a << ror_left);
        mul_val   = a * b;
    end

    // ------------------------------------------------------------------
    // Result and flag selection
    // ------------------------------------------------------------------
    logic res_n;
    logic res_v;
    logic res_c;
    logic res_z;

    always_comb begin
        result_d = '0;
        res_c    = flags_in[1];
        res_v    = flags_in[2];
        case (oper)
            C_OP_ADD, C_OP_ADC, C_OP_SUB, C_OP_SBC, C_OP_RSB: begin
                result_d = arith_sum[WIDTH-1:0];
                res_c    = arith_sum[WIDTH];
                // Overflow: addends agree in sign, sum sign differs.
                res_v    = (arith_x[WIDTH-1] == arith_y[WIDTH-1]) &&
                           (arith_sum[WIDTH-1] != arith_x[WIDTH-1]);
            end
            C_OP_MUL: result_d = mul_val;
            C_OP_AND: result_d = a & b;
            C_OP_ORR: result_d = a | b;
            C_OP_XOR: result_d = a ^ b;
            C_OP_BIC: result_d = a & ~b;
            C_OP_CPY: result_d = b;
            C_OP_LSL: begin
                if (amt_zero) begin
                    result_d = a;
                end else if (amt_small) begin
                    result_d = lsl_tmp[WIDTH-1:0];
                    res_c    = lsl_tmp[WIDTH];
                end else if (amt_full) begin
                    result_d = '0;
                    res_c    = a[0];
                end else begin
                    result_d = '0;
                    res_c    = 1'b0;
                end
            end
            C_OP_LSR: begin
                if (amt_zero) begin
                    result_d = a;
                end else if (amt_small) begin
                    result_d = lsr_tmp[WIDTH:1];
                    res_c    = lsr_tmp[0];
                end else if (amt_full) begin
                    result_d = '0;
                    res_c    = a[WIDTH-1];
                end else begin
                    result_d = '0;
                    res_c    = 1'b0;
                end
            end
            C_OP_ASR: begin
                if (amt_zero) begin
                    result_d = a;
                end else if (amt_small) begin
                    result_d = asr_tmp[WIDTH:1];
                    res_c    = asr_tmp[0];
                end else begin
                    // Full-width or larger: sign fills every bit.
                    result_d = {WIDTH{a[WIDTH-1]}};
                    res_c    = a[WIDTH-1];
                end
            end
            C_OP_ROR: begin
                // Rotation distance is modulo the width; upper b bits ignored.
                result_d = ror_val;
                if (amt_lo != '0) begin
                    res_c = ror_val[WIDTH-1];
                end
            end
            default: result_d = '0;
        endcase

        res_z = (result_d == '0);
        res_n = result_d[WIDTH-1];

        // Reserved opcode passes the incoming flags through untouched.
        if (oper == 4'd15) begin
            flags_d = flags_in;
        end else begin
            flags_d = {res_n, res_v, res_c, res_z};
        end
    end

    // ------------------------------------------------------------------
    // Output registers: reset wins over a same-cycle operation, and the
    // result/flags hold whenever no operation is presented.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign result    = result_q;
    assign flags_out = flags_q;
    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_alu
// Purpose  : Self-checking bench for cpu_alu. A table of operations is
//            driven back-to-back; each expected result/flags pair is queued
//            when driven and compared when out_valid appears. Reset, hold and
//            reset-versus-operation cases are written out by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_alu;

    typedef struct {
        logic [3:0]  oper;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fin;
        logic [31:0] exp_res;
        logic [3:0]  exp_fl;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  oper;
    logic [3:0]  flags_in;
    logic [31:0] result;
    logic [3:0]  flags_out;
    logic        out_valid;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    vec_t vecs[$];

    cpu_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .oper      (oper),
        .flags_in  (flags_in),
        .result    (result),
        .flags_out (flags_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                           input logic [3:0] fi, input logic [31:0] er, input logic [3:0] ef);
        vec_t v;
        v.oper = op; v.a = va; v.b = vb; v.fin = fi; v.exp_res = er; v.exp_fl = ef;
        vecs.push_back(v);
    endtask

    // Monitor: out_valid must follow an accepted operation by one cycle;
    // each pulse is matched against the oldest queued expectation.
    always begin
        logic exp_v;
        @(posedge clk);
        exp_v = in_valid && !rst;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%08h expected no output", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("vec%0d_result", e.idx), result, e.res);
                chk($sformatf("vec%0d_flags", e.idx), {28'd0, flags_out}, {28'd0, e.fl});
            end
        end
    end

    initial begin
        // Flag nibble is {N,V,C,Z}.
        add_vec(4'd0,  32'h7FFFFFFF, 32'h00000001, 4'b0000, 32'h80000000, 4'b1100); // ADD overflow
        add_vec(4'd2,  32'h00000005, 32'h00000005, 4'b0000, 32'h00000000, 4'b0011); // SUB equal
        add_vec(4'd3,  32'h00000000, 32'h00000000, 4'b0000, 32'hFFFFFFFF, 4'b1000); // SBC borrow
        add_vec(4'd1,  32'hFFFFFFFF, 32'h00000000, 4'b0010, 32'h00000000, 4'b0011); // ADC wrap
        add_vec(4'd4,  32'h00000001, 32'h00000003, 4'b0000, 32'h00000002, 4'b0010); // RSB
        add_vec(4'd0,  32'h80000000, 32'h80000000, 4'b0000, 32'h00000000, 4'b0111); // ADD neg ovf
        add_vec(4'd5,  32'h00010000, 32'h00010000, 4'b0110, 32'h00000000, 4'b0111); // MUL wrap
        add_vec(4'd5,  32'h00000003, 32'h00000005, 4'b0000, 32'h0000000F, 4'b0000); // MUL
        add_vec(4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 4'b0110, 32'hF000F000, 4'b1110); // AND
        add_vec(4'd7,  32'h0000000F, 32'h000000F0, 4'b0000, 32'h000000FF, 4'b0000); // ORR
        add_vec(4'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 32'h00000000, 4'b0001); // XOR
        add_vec(4'd9,  32'h000000FF, 32'h0000000F, 4'b0000, 32'h000000F0, 4'b0000); // BIC
        add_vec(4'd14, 32'h12345678, 32'h80000000, 4'b0100, 32'h80000000, 4'b1100); // CPY
        add_vec(4'd10, 32'h80000001, 32'h00000001, 4'b0000, 32'h00000002, 4'b0010); // LSL 1
        add_vec(4'd11, 32'h80000000, 32'h00000020, 4'b0000, 32'h00000000, 4'b0011); // LSR 32
        add_vec(4'd12, 32'h80000000, 32'h00000028, 4'b0000, 32'hFFFFFFFF, 4'b1010); // ASR 40
        add_vec(4'd13, 32'h00000001, 32'h00000001, 4'b0000, 32'h80000000, 4'b1010); // ROR 1
        add_vec(4'd10, 32'h00001234, 32'h00000000, 4'b0010, 32'h00001234, 4'b0010); // LSL 0
        add_vec(4'd10, 32'h00000001, 32'h00000020, 4'b0000, 32'h00000000, 4'b0011); // LSL 32
        add_vec(4'd11, 32'hFFFFFFFF, 32'h00000021, 4'b0010, 32'h00000000, 4'b0001); // LSR 33
        add_vec(4'd12, 32'h70000000, 32'h00000004, 4'b0000, 32'h07000000, 4'b0000); // ASR 4
        add_vec(4'd11, 32'h00000003, 32'h00000001, 4'b0000, 32'h00000001, 4'b0010); // LSR 1
        add_vec(4'd13, 32'h12345678, 32'h00000020, 4'b0010, 32'h12345678, 4'b0010); // ROR b[4:0]=0
        add_vec(4'd15, 32'h00000005, 32'h00000006, 4'b1010, 32'h00000000, 4'b1010); // reserved
        add_vec(4'd10, 32'h00000001, 32'h0000001F, 4'b0000, 32'h80000000, 4'b1000); // LSL 31

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; oper = '0; flags_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: outputs stay at reset values.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("idle%0d_result", i), result, 32'h0);
            chk($sformatf("idle%0d_flags", i), {28'd0, flags_out}, 32'h0);
        end

        // Table applied back-to-back, one operation per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge clk);
            in_valid = 1'b1;
            oper     = vecs[i].oper;
            a        = vecs[i].a;
            b        = vecs[i].b;
            flags_in = vecs[i].fin;
            e.res = vecs[i].exp_res;
            e.fl  = vecs[i].exp_fl;
            e.idx = i;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h1; oper = 4'd0; flags_in = 4'hF;

        // Hold: with in_valid low, the last result/flags persist.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_result", result, 32'h80000000);
        chk("hold_flags", {28'd0, flags_out}, {28'd0, 4'b1000});

        // Reset together with an operation: operation dropped.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; oper = 4'd0; a = 32'h1; b = 32'h1; flags_in = 4'h0;
        @(posedge clk); #1;
        chk("rst_op_result", result, 32'h0);
        chk("rst_op_flags", {28'd0, flags_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_result", result, 32'h0);
        chk("post_rst_flags", {28'd0, flags_out}, 32'h0);

        // Every queued expectation must have been consumed.
        chk("scoreboard_empty", sb.size(), 32'd0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
